// File: rtl/dot_rr_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dot_rr_scheduler                                                |
// | Purpose  : Round-robin arbiter that shares one multi-cycle sequential      |
// |            dot-product engine among NUM_REQ requesters. Latches the        |
// |            granted operand pair, issues a one-cycle start pulse, waits     |
// |            for the engine result and returns it tagged with the ID.        |
// | Option   : DOT_SCHED_TIMEOUT_EN adds a WAIT watchdog and res_err_out.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module dot_rr_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int N              = 3,
  parameter int A_WIDTH        = 16,
  parameter int B_WIDTH        = 16,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int ACC_WIDTH     = A_WIDTH + B_WIDTH + $clog2(N),
  localparam int ID_WIDTH      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                      clk_in,
  input  logic                                      rst_in,
  input  logic [NUM_REQ-1:0]                        req_valid_in,
  output logic [NUM_REQ-1:0]                        req_ready_out,
  input  logic [NUM_REQ-1:0][N-1:0][A_WIDTH-1:0]    req_a_in,
  input  logic [NUM_REQ-1:0][N-1:0][B_WIDTH-1:0]    req_b_in,
  output logic [N-1:0][A_WIDTH-1:0]                 eng_a_out,
  output logic [N-1:0][B_WIDTH-1:0]                 eng_b_out,
  output logic                                      eng_valid_out,
  input  logic                                      eng_valid_in,
  input  logic [ACC_WIDTH-1:0]                      eng_p_in,
  output logic                                      res_valid_out,
  input  logic                                      res_ready_in,
  output logic [ACC_WIDTH-1:0]                      res_p_out,
  output logic [ID_WIDTH-1:0]                       res_id_out,
  output logic                                      busy_out
`ifdef DOT_SCHED_TIMEOUT_EN
  ,
  output logic                                      res_err_out
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] grant_idx;
  logic [ID_WIDTH-1:0] next_ptr;
  logic                grant_found;
  logic [ID_WIDTH:0]   cand;

`ifdef DOT_SCHED_TIMEOUT_EN
  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_WIDTH-1:0] wait_cnt;
`else
  // The watchdog limit has no role when the watchdog is not built.
  logic [31:0] timeout_cfg_unused;
  assign timeout_cfg_unused = TIMEOUT_CYCLES;
`endif

  // Find the first valid requester at or above rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (ID_WIDTH + 1)'(k);
      if (cand >= (ID_WIDTH + 1)'(NUM_REQ)) begin
        cand = cand - (ID_WIDTH + 1)'(NUM_REQ);
      end
      if (!grant_found && req_valid_in[cand[ID_WIDTH-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_WIDTH-1:0];
      end
    end
  end

  // Pointer moves to the requester just after the one granted.
  assign next_ptr = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // Acceptance is offered only while idle and out of reset; at most one bit set.
  always_comb begin
    req_ready_out = '0;
    if ((state == IDLE) && grant_found && !rst_in) begin
      req_ready_out[grant_idx] = 1'b1;
    end
  end

  // Job sequencer: grant and latch, single start pulse, wait for engine, hold result until taken.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      eng_a_out     <= '0;
      eng_b_out     <= '0;
      eng_valid_out <= 1'b0;
      res_valid_out <= 1'b0;
      res_p_out     <= '0;
      res_id_out    <= '0;
      busy_out      <= 1'b0;
`ifdef DOT_SCHED_TIMEOUT_EN
      wait_cnt      <= '0;
      res_err_out   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            eng_a_out     <= req_a_in[grant_idx];
            eng_b_out     <= req_b_in[grant_idx];
            res_id_out    <= grant_idx;
            rr_ptr        <= next_ptr;
            eng_valid_out <= 1'b1;
            busy_out      <= 1'b1;
            state         <= ISSUE;
`ifdef DOT_SCHED_TIMEOUT_EN
            res_err_out   <= 1'b0;
`endif
          end
        end
        ISSUE: begin
          // Start is a pulse: holding it would restart the engine.
          eng_valid_out <= 1'b0;
          state         <= WAIT;
`ifdef DOT_SCHED_TIMEOUT_EN
          wait_cnt      <= '0;
`endif
        end
        WAIT: begin
          if (eng_valid_in) begin
            res_p_out     <= eng_p_in;
            res_valid_out <= 1'b1;
            state         <= RESP;
          end
`ifdef DOT_SCHED_TIMEOUT_EN
          else if (wait_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
            res_p_out     <= '0;
            res_err_out   <= 1'b1;
            res_valid_out <= 1'b1;
            state         <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (res_ready_in) begin
            res_valid_out <= 1'b0;
            busy_out      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dot_rr_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dot_rr_scheduler                                             |
// | Purpose  : Self-checking bench for dot_rr_scheduler with a job-level       |
// |            reference model and a behavioural engine with random latency.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_dot_rr_scheduler;

  localparam int NUM_REQ   = 4;
  localparam int N         = 3;
  localparam int A_WIDTH   = 16;
  localparam int B_WIDTH   = 16;
  localparam int ACC_WIDTH = A_WIDTH + B_WIDTH + $clog2(N);
  localparam int ID_WIDTH  = $clog2(NUM_REQ);

  logic                                   clk_in = 1'b0;
  logic                                   rst_in;
  logic [NUM_REQ-1:0]                     req_valid_in;
  logic [NUM_REQ-1:0]                     req_ready_out;
  logic [NUM_REQ-1:0][N-1:0][A_WIDTH-1:0] req_a_in;
  logic [NUM_REQ-1:0][N-1:0][B_WIDTH-1:0] req_b_in;
  logic [N-1:0][A_WIDTH-1:0]              eng_a_out;
  logic [N-1:0][B_WIDTH-1:0]              eng_b_out;
  logic                                   eng_valid_out;
  logic                                   eng_valid_in;
  logic [ACC_WIDTH-1:0]                   eng_p_in;
  logic                                   res_valid_out;
  logic                                   res_ready_in;
  logic [ACC_WIDTH-1:0]                   res_p_out;
  logic [ID_WIDTH-1:0]                    res_id_out;
  logic                                   busy_out;
`ifdef DOT_SCHED_TIMEOUT_EN
  logic                                   res_err_out;
`endif

  dot_rr_scheduler #(
    .NUM_REQ (NUM_REQ),
    .N       (N),
    .A_WIDTH (A_WIDTH),
    .B_WIDTH (B_WIDTH)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .req_valid_in  (req_valid_in),
    .req_ready_out (req_ready_out),
    .req_a_in      (req_a_in),
    .req_b_in      (req_b_in),
    .eng_a_out     (eng_a_out),
    .eng_b_out     (eng_b_out),
    .eng_valid_out (eng_valid_out),
    .eng_valid_in  (eng_valid_in),
    .eng_p_in      (eng_p_in),
    .res_valid_out (res_valid_out),
    .res_ready_in  (res_ready_in),
    .res_p_out     (res_p_out),
    .res_id_out    (res_id_out),
    .busy_out      (busy_out)
`ifdef DOT_SCHED_TIMEOUT_EN
    ,
    .res_err_out   (res_err_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  // Job lifecycle phases as the scheduler must expose them.
  typedef enum int {M_IDLE, M_ISSUE, M_WAIT, M_RESP} mphase_t;

  int n_cmp = 0;
  int n_err = 0;

  mphase_t                   m_phase;
  int                        m_rr;
  int                        m_id;
  longint                    m_p;
  logic [N-1:0][A_WIDTH-1:0] m_a;
  logic [N-1:0][B_WIDTH-1:0] m_b;

  int     eng_cnt;
  longint eng_prod;
  int     lat_min;
  int     lat_max;
  bit     spur_en;
  bit     spur_force;
  int     n_pulses;
  int     dut_grants[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint dotp(input logic [N-1:0][A_WIDTH-1:0] a,
                                  input logic [N-1:0][B_WIDTH-1:0] b);
    longint s;
    s = 0;
    for (int i = 0; i < N; i++) begin
      s += longint'($signed(a[i])) * longint'($signed(b[i]));
    end
    return s;
  endfunction

  // First valid requester at or after rr, wrapping; -1 when none.
  function automatic int pick(input logic [NUM_REQ-1:0] v, input int rr);
    logic [NUM_REQ-1:0] sh;
    int idx;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (rr + k) % NUM_REQ;
      sh  = v >> idx;
      if (sh[0]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = M_IDLE;
    m_rr    = 0;
    m_id    = 0;
    m_p     = 0;
    m_a     = '0;
    m_b     = '0;
    eng_cnt = 0;
  endtask

  task automatic rand_vectors();
    for (int r = 0; r < NUM_REQ; r++) begin
      for (int e = 0; e < N; e++) begin
        req_a_in[r][e] = A_WIDTH'($urandom);
        req_b_in[r][e] = B_WIDTH'($urandom);
      end
    end
  endtask

  // One clock cycle: engine drive, compare against the model, advance the model.
  task automatic step();
    logic [ACC_WIDTH-1:0] exp_p;
    logic [NUM_REQ-1:0]   exp_ready;
    logic [ID_WIDTH-1:0]  gi;
    int g;
    eng_valid_in = 1'b0;
    eng_p_in     = ACC_WIDTH'({$urandom, $urandom});
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        eng_valid_in = 1'b1;
        eng_p_in     = ACC_WIDTH'(eng_prod);
      end
    end else if (m_phase != M_WAIT && (spur_force || (spur_en && $urandom_range(0, 3) == 0))) begin
      eng_valid_in = 1'b1;
    end
    #1;
    if (eng_valid_out) n_pulses++;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (req_ready_out[j]) dut_grants.push_back(j);
    end

    g = pick(req_valid_in, m_rr);
    exp_ready = '0;
    if (m_phase == M_IDLE && !rst_in && g >= 0) exp_ready = NUM_REQ'(1) << g;
    chk("req_ready", 64'(req_ready_out), 64'(exp_ready));
    chk("busy", 64'(busy_out), 64'(m_phase != M_IDLE));
    chk("eng_valid", 64'(eng_valid_out), 64'(m_phase == M_ISSUE));
    chk("res_valid", 64'(res_valid_out), 64'(m_phase == M_RESP));
    chk("eng_a", 64'(eng_a_out), 64'(m_a));
    chk("eng_b", 64'(eng_b_out), 64'(m_b));
    if (m_phase == M_RESP) begin
      exp_p = m_p[ACC_WIDTH-1:0];
      chk("res_p", 64'(res_p_out), 64'(exp_p));
      chk("res_id", 64'(res_id_out), 64'(m_id));
`ifdef DOT_SCHED_TIMEOUT_EN
      chk("res_err", 64'(res_err_out), 64'd0);
`endif
    end

    case (m_phase)
      M_IDLE: begin
        if (g >= 0 && !rst_in) begin
          gi      = ID_WIDTH'(g);
          m_id    = g;
          m_a     = req_a_in[gi];
          m_b     = req_b_in[gi];
          m_p     = dotp(m_a, m_b);
          m_rr    = (g + 1) % NUM_REQ;
          m_phase = M_ISSUE;
        end
      end
      M_ISSUE: begin
        // The engine computes from whatever operands the scheduler presents.
        eng_prod = dotp(eng_a_out, eng_b_out);
        eng_cnt  = $urandom_range(lat_min, lat_max);
        m_phase  = M_WAIT;
      end
      M_WAIT: if (eng_valid_in) m_phase = M_RESP;
      M_RESP: if (res_ready_in) m_phase = M_IDLE;
      default: m_phase = M_IDLE;
    endcase
    @(negedge clk_in);
  endtask

  task automatic apply_reset();
    rst_in = 1'b1;
    #1;
    chk("rst_ready", 64'(req_ready_out), 64'd0);
    chk("rst_busy", 64'(busy_out), 64'd0);
    chk("rst_eng_valid", 64'(eng_valid_out), 64'd0);
    chk("rst_res_valid", 64'(res_valid_out), 64'd0);
    chk("rst_res_p", 64'(res_p_out), 64'd0);
    chk("rst_res_id", 64'(res_id_out), 64'd0);
    chk("rst_eng_a", 64'(eng_a_out), 64'd0);
    chk("rst_eng_b", 64'(eng_b_out), 64'd0);
    model_reset();
    step();
    step();
    rst_in = 1'b0;
  endtask

  task automatic run_to_resp(input string name);
    for (int i = 0; i < 40 && m_phase != M_RESP; i++) step();
    chk(name, 64'(res_valid_out), 64'd1);
  endtask

  initial begin
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    rst_in       = 1'b1;
    req_valid_in = '0;
    req_a_in     = '0;
    req_b_in     = '0;
    res_ready_in = 1'b0;
    eng_valid_in = 1'b0;
    eng_p_in     = '0;
    spur_en      = 1'b0;
    spur_force   = 1'b0;
    lat_min      = 1;
    lat_max      = 4;
    n_pulses     = 0;
    model_reset();
    @(negedge clk_in);
    req_valid_in = 4'b1111;  // ready must stay low while in reset
    apply_reset();
    req_valid_in = '0;

    // Single job from requester 2: A={1.0,0.5,0}, B={1,1,1} in Q2.14 -> 1.5 in Q.28.
    req_a_in[2]  = {16'h0000, 16'h2000, 16'h4000};
    req_b_in[2]  = {16'h4000, 16'h4000, 16'h4000};
    req_valid_in = 4'b0100;
    res_ready_in = 1'b1;
    lat_min = 3;
    lat_max = 3;
    n_pulses = 0;
    step();
    req_valid_in = '0;
    run_to_resp("single_reach");
    chk("single_p", 64'(res_p_out), 64'h1800_0000);
    chk("single_id", 64'(res_id_out), 64'd2);
    chk("single_pulses", 64'(n_pulses), 64'd1);
    step();

    // All requesters valid from rr_ptr=0: grants must rotate 0,1,2,3,0.
    apply_reset();
    rand_vectors();
    req_valid_in = 4'b1111;
    lat_min = 1;
    lat_max = 4;
    dut_grants.delete();
    for (int i = 0; i < 200 && dut_grants.size() < 5; i++) step();
    chk("rr_count", 64'(dut_grants.size() >= 5), 64'd1);
    for (int i = 0; i < 5 && i < dut_grants.size(); i++) begin
      chk("rr_order", 64'(dut_grants[i]), 64'(exp_order[i]));
    end
    req_valid_in = '0;
    for (int i = 0; i < 20 && m_phase != M_IDLE; i++) step();

    // Consumer stalls 10 cycles in RESP; other requesters must not be accepted.
    res_ready_in = 1'b0;
    req_valid_in = 4'b0010;
    step();
    req_valid_in = 4'b1111;
    run_to_resp("hold_reach");
    repeat (10) step();
    chk("hold_valid", 64'(res_valid_out), 64'd1);
    chk("hold_id", 64'(res_id_out), 64'd1);
    res_ready_in = 1'b1;
    req_valid_in = '0;
    step();

    // Spurious engine pulses while idle must be ignored.
    spur_force = 1'b1;
    repeat (3) step();
    spur_force = 1'b0;
    chk("spur_busy", 64'(busy_out), 64'd0);
    chk("spur_res_valid", 64'(res_valid_out), 64'd0);

    // Reset during WAIT drops the job; the next job from requester 3 completes normally.
    lat_min = 6;
    lat_max = 6;
    req_valid_in = 4'b0010;
    step();
    req_valid_in = '0;
    for (int i = 0; i < 5 && m_phase != M_WAIT; i++) step();
    step();
    apply_reset();
    rand_vectors();
    lat_min = 1;
    lat_max = 4;
    req_valid_in = 4'b1000;
    step();
    req_valid_in = '0;
    run_to_resp("post_rst_reach");
    chk("post_rst_id", 64'(res_id_out), 64'd3);
    step();

    // Randomized traffic with backpressure, spurious pulses and one reset mid-stream.
    spur_en = 1'b1;
    lat_max = 5;
    for (int c = 0; c < 800; c++) begin
      if (c == 400) apply_reset();
      req_valid_in = NUM_REQ'($urandom);
      rand_vectors();
      res_ready_in = ($urandom_range(0, 9) < 7);
      step();
    end
    spur_en = 1'b0;
    req_valid_in = '0;
    res_ready_in = 1'b1;
    repeat (12) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
